// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - state_t        : 4-bit FSM state encoding (also exported on state_o)
//   - OP_* / FN_*    : instruction opcode and R-type funct constants
//   - ALU_*          : alu_control code set (lui = 1110)
//   - PCSRC_*, SRCB_*, RDST_*, M2R_* : datapath mux select encodings
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // alu_control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLLV = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b1100;
    localparam logic [3:0] ALU_SRAV = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    // pc_src
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // alu_src_b
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // reg_dst
    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    // mem_to_reg
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational map from (opcode, funct) to the ALU operation code used in
// EXEC_R / EXEC_I, plus a flag telling whether the pair is an ALU operation
// this unit knows. jr is not an ALU op and reports not-legal here; the FSM
// decodes it separately.
// Ports:
//   i_opcode      in  6  IR[31:26]
//   i_funct       in  6  IR[5:0]
//   o_alu_control out 4  ALU operation code
//   o_legal       out 1  1 = recognised R-type funct or I-type ALU opcode
// ---------------------------------------------------------------------------
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_legal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_legal       = 1'b1;
        if (i_opcode == OP_RTYPE) begin
            case (i_funct)
                FN_ADD, FN_ADDU: o_alu_control = ALU_ADD;
                FN_SUB, FN_SUBU: o_alu_control = ALU_SUB;
                FN_AND:          o_alu_control = ALU_AND;
                FN_OR:           o_alu_control = ALU_OR;
                FN_XOR:          o_alu_control = ALU_XOR;
                FN_NOR:          o_alu_control = ALU_NOR;
                FN_SLT:          o_alu_control = ALU_SLT;
                FN_SLTU:         o_alu_control = ALU_SLTU;
                FN_SLL:          o_alu_control = ALU_SLL;
                FN_SRL:          o_alu_control = ALU_SRL;
                FN_SRA:          o_alu_control = ALU_SRA;
                FN_SLLV:         o_alu_control = ALU_SLLV;
                FN_SRLV:         o_alu_control = ALU_SRLV;
                FN_SRAV:         o_alu_control = ALU_SRAV;
                default:         o_legal       = 1'b0;
            endcase
        end else begin
            case (i_opcode)
                OP_ADDI, OP_ADDIU: o_alu_control = ALU_ADD;
                OP_SLTI:           o_alu_control = ALU_SLT;
                OP_SLTIU:          o_alu_control = ALU_SLTU;
                OP_ANDI:           o_alu_control = ALU_AND;
                OP_ORI:            o_alu_control = ALU_OR;
                OP_XORI:           o_alu_control = ALU_XOR;
                OP_LUI:            o_alu_control = ALU_LUI;
                default:           o_legal       = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// write-back over a single shared memory port handshaken with mem_ready.
// Outputs are decoded from the registered state (plus opcode/funct, zero in
// BRANCH, and mem_ready in the memory states), so an asynchronous reset
// forces every output to 0 immediately.
// Parameters:
//   SUPPORT_LINK  1 = decode jal/jr, 0 = treat them as illegal
//   MEM_TIMEOUT   0 = no timeout, N = abort after N cycles of mem_ready=0
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode, funct, zero     IR fields and ALU zero flag
//   mem_ready               memory handshake
//   mem_read, mem_write     memory request
//   iord                    address select (0 PC, 1 ALUOut)
//   ir_write, pc_en, pc_src IR load, PC enable, PC source
//   alu_src_a/b, alu_control ALU operand selects and operation
//   reg_write, reg_dst, mem_to_reg  register file write controls
//   illegal, bus_err, instr_done    one-cycle status pulses
//   state_o                 current state
// ---------------------------------------------------------------------------
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int SUPPORT_LINK = 1,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal,
    output logic       bus_err,
    output logic       instr_done,
    output logic [3:0] state_o
);

    // A 1-bit counter is kept even when the timeout is disabled so the
    // declaration stays legal; it is then held at 0.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        r_state;
    logic [CW-1:0] r_wait;

    state_t        w_dec_next;
    logic          w_dec_illegal;
    logic          w_in_mem;
    logic          w_timeout;
    logic [3:0]    w_alu_ctl;
    logic          w_alu_legal;
    logic          w_is_jr;
    logic          w_is_jal;

    alu_decoder u_alu_decoder (
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_alu_control (w_alu_ctl),
        .o_legal       (w_alu_legal)
    );

    assign w_is_jr  = (SUPPORT_LINK != 0) && (opcode == OP_RTYPE) && (funct == FN_JR);
    assign w_is_jal = (SUPPORT_LINK != 0) && (opcode == OP_JAL);

    assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // Fires in the N-th consecutive wait cycle: the counter holds N-1 here.
    assign w_timeout = (MEM_TIMEOUT > 0) && w_in_mem && !mem_ready && (r_wait == TO_LAST);

    assign state_o = r_state;

    // Instruction class decode used on the DECODE -> next transition.
    always_comb begin
        w_dec_next    = S_FETCH;
        w_dec_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW: w_dec_next = S_MEM_ADDR;
            OP_RTYPE: begin
                if (w_is_jr)          w_dec_next = S_JR;
                else if (w_alu_legal) w_dec_next = S_EXEC_R;
                else                  w_dec_illegal = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: w_dec_next = S_EXEC_I;
            OP_BEQ, OP_BNE: w_dec_next = S_BRANCH;
            OP_J:           w_dec_next = S_JUMP;
            OP_JAL: begin
                if (w_is_jal) w_dec_next = S_JUMP;
                else          w_dec_illegal = 1'b1;
            end
            default:        w_dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            // The counter is zero whenever a memory state is entered, because
            // every exit path from a memory state clears it.
            if ((MEM_TIMEOUT > 0) && w_in_mem && !mem_ready && !w_timeout)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;

            case (r_state)
                S_IDLE:     r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_timeout)      r_state <= S_IDLE;
                    else if (mem_ready) r_state <= S_DECODE;
                end
                S_DECODE:   r_state <= w_dec_next;
                S_MEM_ADDR: r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (w_timeout)      r_state <= S_IDLE;
                    else if (mem_ready) r_state <= S_WB_MEM;
                end
                S_MEM_WR: begin
                    if (w_timeout)      r_state <= S_IDLE;
                    else if (mem_ready) r_state <= S_FETCH;
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
                S_WB_MEM, S_WB_ALU, S_BRANCH,
                S_JUMP, S_JR:       r_state <= S_FETCH;
                default:            r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = RDST_RT;
        mem_to_reg  = M2R_ALUOUT;
        illegal     = 1'b0;
        bus_err     = w_timeout;
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read; IR and PC
                // update together in the cycle memory completes.
                mem_read  = !w_timeout;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMMSH;
                illegal    = w_dec_illegal;
                instr_done = w_dec_illegal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = !w_timeout;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = !w_timeout;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = w_alu_ctl;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = w_alu_ctl;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE) ? RDST_RD : RDST_RT;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
                pc_en       = (opcode == OP_BNE) ? ~zero : zero;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                if (w_is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = RDST_RA;
                    mem_to_reg = M2R_PC;
                end
            end
            S_JR: begin
                pc_src     = PCSRC_REGA;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
